// File: rtl/data_mem_resp.sv
// Responder end of the data memory req/gnt/rvalid interface: word RAM with byte
// enables, programmable grant wait states and a fixed one-cycle response.
module data_mem_resp #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_in,
    input  logic [31:0] data_add_in,
    input  logic        data_we_in,
    input  logic [3:0]  data_be_in,
    input  logic [31:0] data_wdata_in,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        gnt;

    logic [31:0] mem [DEPTH];
    logic [31:0] mem_rdata;
    logic        rvalid_q;
    logic        rd_q;
    logic        err_q;

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          unused_addr;

    assign word_idx    = data_add_in[AW+1:2];
    assign in_range    = data_add_in[31:2] < DEPTH_W;
    assign unused_addr = ^data_add_in[1:0];

    // wait_cnt holds the number of idle cycles still owed before the grant.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        gnt          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (NO_WAIT) begin
                    gnt = data_req_in;
                end else if (data_req_in) begin
                    wait_cnt_nxt = 4'(WAIT_STATES - 1);
                    state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!data_req_in) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == '0) begin
                    gnt       = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            gnt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            rvalid_q <= 1'b0;
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            rvalid_q <= gnt;
            rd_q     <= gnt && !data_we_in && in_range;
            err_q    <= gnt && !in_range;
        end
    end

    // NOTE: the RAM array is deliberately not reset, so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (gnt && data_we_in && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be_in[i]) begin
                    mem[word_idx][8*i +: 8] <= data_wdata_in[8*i +: 8];
                end
            end
        end
        mem_rdata <= mem[word_idx];
    end

    // Responses are gated so that every output reads as zero while reset is held.
    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q && !rst;
    assign data_rdata_o  = (rd_q && !rst) ? mem_rdata : '0;
    assign data_err_o    = err_q && !rst;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a zero-wait instance for data-path and
// pipelining checks, a three-wait instance for grant timing.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req3 = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;

    logic        gnt0, rvalid0, err0;
    logic [31:0] rdata0;
    logic        gnt3, rvalid3, err3;
    logic [31:0] rdata3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .clk          (clk),
        .rst          (rst),
        .data_req_in  (req0),
        .data_add_in  (addr),
        .data_we_in   (we),
        .data_be_in   (be),
        .data_wdata_in(wdata),
        .data_gnt_o   (gnt0),
        .data_rvalid_o(rvalid0),
        .data_rdata_o (rdata0),
        .data_err_o   (err0)
    );

    data_mem_resp #(.DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .clk          (clk),
        .rst          (rst),
        .data_req_in  (req3),
        .data_add_in  (addr),
        .data_we_in   (we),
        .data_be_in   (be),
        .data_wdata_in(wdata),
        .data_gnt_o   (gnt3),
        .data_rvalid_o(rvalid3),
        .data_rdata_o (rdata3),
        .data_err_o   (err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request to the zero-wait instance and expect an immediate grant.
    task automatic issue0(input string tag, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        req0 = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1;
        check({tag, " gnt"}, 32'(gnt0), 32'd1);
    endtask

    task automatic idle0();
        req0 = 1'b0; we = 1'b0;
    endtask

    task automatic resp0(input string tag, input logic [31:0] d, input logic e);
        check({tag, " rvalid"}, 32'(rvalid0), 32'd1);
        check({tag, " rdata"}, rdata0, d);
        check({tag, " err"}, 32'(err0), 32'(e));
    endtask

    // Hold a request on the three-wait instance, count cycles to grant, then
    // check the response pulse on the following cycle.
    task automatic access3(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rdata);
        int n = 0;
        req3 = 1'b1; we = w; addr = a; be = 4'hF; wdata = d;
        #1;
        while (gnt3 !== 1'b1 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, " wait cycles"}, 32'(n), 32'd3);
        @(posedge clk);
        #1;
        req3 = 1'b0;
        #1;
        check({tag, " rvalid"}, 32'(rvalid3), 32'd1);
        check({tag, " rdata"}, rdata3, exp_rdata);
        check({tag, " err"}, 32'(err3), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;

        // Reset for two cycles; outputs must all be zero, even with a request pending.
        step();
        step();
        req0 = 1'b1;
        #1;
        check("reset gnt0", 32'(gnt0), 32'd0);
        check("reset rvalid0", 32'(rvalid0), 32'd0);
        check("reset rdata0", rdata0, 32'd0);
        check("reset err0", 32'(err0), 32'd0);
        check("reset gnt3", 32'(gnt3), 32'd0);
        req0 = 1'b0;
        rst  = 1'b0;

        // Write then pipelined read of the same word.
        issue0("wr 0x10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        step();
        resp0("wr 0x10 resp", 32'h0, 1'b0);
        issue0("rd 0x10", 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        resp0("rd 0x10 resp", 32'hDEADBEEF, 1'b0);

        // Byte-enable merge, then an all-disabled write.
        issue0("wr be4", 1'b1, 32'h10, 4'b0100, 32'h00AA0000);
        step();
        resp0("wr be4 resp", 32'h0, 1'b0);
        issue0("rd merged", 1'b0, 32'h10, 4'h0, 32'h0);
        step();
        resp0("rd merged resp", 32'hDEAABEEF, 1'b0);
        issue0("wr be0", 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
        step();
        resp0("wr be0 resp", 32'h0, 1'b0);
        issue0("rd after be0", 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        resp0("rd after be0 resp", 32'hDEAABEEF, 1'b0);

        // Back-to-back writes and reads, one grant per cycle.
        issue0("wr 0x0", 1'b1, 32'h0, 4'hF, 32'h11111111);
        step();
        issue0("wr 0x4", 1'b1, 32'h4, 4'hF, 32'h22222222);
        step();
        issue0("wr 0x8", 1'b1, 32'h8, 4'hF, 32'h33333333);
        step();
        idle0();
        #1;
        check("idle gnt0", 32'(gnt0), 32'd0);
        resp0("wr 0x8 resp", 32'h0, 1'b0);
        step();
        issue0("pipe rd 0x0", 1'b0, 32'h0, 4'hF, 32'h0);
        step();
        resp0("pipe rd 0x0 resp", 32'h11111111, 1'b0);
        issue0("pipe rd 0x4", 1'b0, 32'h4, 4'h0, 32'h0);
        step();
        resp0("pipe rd 0x4 resp", 32'h22222222, 1'b0);
        issue0("pipe rd 0x8", 1'b0, 32'h8, 4'hF, 32'h0);
        step();
        resp0("pipe rd 0x8 resp", 32'h33333333, 1'b0);
        idle0();
        step();
        check("pipe single pulse", 32'(rvalid0), 32'd0);

        // Out of range: 0x1000 aliases word 0 in the low bits but must not touch it.
        issue0("oor wr", 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D);
        step();
        resp0("oor wr resp", 32'h0, 1'b1);
        issue0("rd 0x0 after oor", 1'b0, 32'h0, 4'hF, 32'h0);
        step();
        resp0("rd 0x0 after oor resp", 32'h11111111, 1'b0);
        issue0("oor rd", 1'b0, 32'h1004, 4'hF, 32'h0);
        step();
        resp0("oor rd resp", 32'h0, 1'b1);
        idle0();
        step();
        check("err cleared", 32'(err0), 32'd0);

        // Wait states: grant on the fourth cycle of a held request.
        access3("ws3 wr", 1'b1, 32'h20, 32'h12345678, 32'h0);
        step();
        req3 = 1'b1; we = 1'b0; addr = 32'h20;
        step();
        req3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            seen = seen | gnt3 | rvalid3;
            step();
        end
        check("ws3 withdraw no gnt/rvalid", 32'(seen), 32'd0);
        access3("ws3 rd", 1'b0, 32'h20, 32'h0, 32'h12345678);
        step();

        // Reset on a grant cycle drops the request; reset during rvalid hides it.
        req0 = 1'b1; we = 1'b0; addr = 32'h0; rst = 1'b1;
        #1;
        check("rst grant cycle gnt", 32'(gnt0), 32'd0);
        step();
        rst = 1'b0; req0 = 1'b0;
        #1;
        check("rst dropped rvalid", 32'(rvalid0), 32'd0);
        issue0("rd before rst", 1'b0, 32'h0, 4'hF, 32'h0);
        step();
        idle0();
        rst = 1'b1;
        #1;
        check("rst masks rvalid", 32'(rvalid0), 32'd0);
        check("rst masks rdata", rdata0, 32'd0);
        step();
        rst = 1'b0;
        issue0("rd after rst", 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        resp0("rd after rst resp", 32'hDEAABEEF, 1'b0);
        idle0();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
